// File: rtl/btn_sw_debounce_pkg.sv
// Shared constants for the button/switch conditioning stage.
package btn_sw_debounce_pkg;

  // Acceptance time for the 100 MHz board build (10 ms) and for fast simulation builds
  localparam int DEB_CYCLES_BOARD = 1_000_000;
  localparam int DEB_CYCLES_SIM   = 8;

  // Position of the divider STEP select within sw_out
  localparam int STEP_IDX = 0;

  // Counter width needed to hold 0 .. deb-1 with headroom for deb itself
  function automatic int cnt_width(input int deb);
    return $clog2(deb + 1);
  endfunction

endpackage

// File: rtl/btn_sw_debounce_debounce_ch.sv
// One debounced input channel: two-flop synchroniser, stability counter,
// accepted level and an optional registered rising-edge pulse.
module debounce_ch
  import btn_sw_debounce_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_SIM,
  parameter bit EDGE_PULSE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic pulse
);

  localparam int              CNT_W = cnt_width(DEB_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEB_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic             stable;
  logic             pulse_q;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  // The synchronised level has differed from the accepted one for long enough
  assign accept = (s2 != stable) && (cnt == LAST);

  // Bring the asynchronous raw level into the clock domain through two flops
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Count consecutive differing cycles; any return to the accepted level restarts the count
  always_ff @(posedge clk) begin
    if (rst) begin
      stable <= 1'b0;
      cnt    <= '0;
    end else if (s2 == stable) begin
      cnt <= '0;
    end else if (accept) begin
      stable <= s2;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Single-cycle pulse coinciding with an accepted rise of the level
  always_ff @(posedge clk) begin
    if (rst) begin
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= EDGE_PULSE && accept && s2;
    end
  end

  assign level = stable;
  assign pulse = pulse_q;

endmodule

// File: rtl/btn_sw_debounce.sv
// Input conditioning for the board buttons and switches: every input gets its
// own independent synchroniser/debouncer; buttons also produce press pulses.
module btn_sw_debounce
  import btn_sw_debounce_pkg::*;
#(
  parameter int NBTN       = 5,
  parameter int NSW        = 16,
  parameter int DEB_CYCLES = DEB_CYCLES_BOARD
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NBTN-1:0] btn_in,
  input  logic [NSW-1:0]  sw_in,
  output logic [NBTN-1:0] btn_out,
  output logic [NBTN-1:0] btn_pulse,
  output logic [NSW-1:0]  sw_out
);

  // Switches never pulse; their pulse outputs are constant zero and left unused
  logic [NSW-1:0] sw_pulse_unused;

  // Button channels with rising-edge pulses
  for (genvar i = 0; i < NBTN; i++) begin : g_btn
    debounce_ch #(
      .DEB_CYCLES(DEB_CYCLES),
      .EDGE_PULSE(1'b1)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .raw  (btn_in[i]),
      .level(btn_out[i]),
      .pulse(btn_pulse[i])
    );
  end

  // Switch channels, level only; sw_out[STEP_IDX] feeds the divider STEP select
  for (genvar j = 0; j < NSW; j++) begin : g_sw
    debounce_ch #(
      .DEB_CYCLES(DEB_CYCLES),
      .EDGE_PULSE(1'b0)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .raw  (sw_in[j]),
      .level(sw_out[j]),
      .pulse(sw_pulse_unused[j])
    );
  end

endmodule

// File: tb/tb_btn_sw_debounce.sv
// Scoreboard bench: a window-based reference model predicts every output
// cycle for two builds (DEB_CYCLES=8 and 1); a monitor compares each cycle.
module tb_btn_sw_debounce;
  import btn_sw_debounce_pkg::*;

  localparam int NBTN = 5;
  localparam int NSW  = 16;
  localparam int NCH  = NBTN + NSW;
  localparam int DEB_A = DEB_CYCLES_SIM;
  localparam int DEB_B = 1;
  localparam int HMAX  = 8;

  logic            clk;
  logic            rst;
  logic [NBTN-1:0] btn_in;
  logic [NSW-1:0]  sw_in;

  logic [NBTN-1:0] btn_out_a, btn_pulse_a, btn_out_b, btn_pulse_b;
  logic [NSW-1:0]  sw_out_a, sw_out_b;

  int total;
  int bad;
  int cycle;

  logic [25:0] q_a[$];
  logic [25:0] q_b[$];

  // Reference model state: two-stage delay of each raw input, the history of
  // delayed samples, and the currently accepted level.
  bit m_d1   [2][NCH];
  bit m_d2   [2][NCH];
  bit m_st   [2][NCH];
  bit m_hist [2][NCH][HMAX];
  int m_len  [2][NCH];
  bit m_raw, m_pul, m_alldiff;
  int m_deb;
  logic [25:0] m_e;

  btn_sw_debounce #(.NBTN(NBTN), .NSW(NSW), .DEB_CYCLES(DEB_A)) dut_a (
    .clk(clk), .rst(rst), .btn_in(btn_in), .sw_in(sw_in),
    .btn_out(btn_out_a), .btn_pulse(btn_pulse_a), .sw_out(sw_out_a)
  );

  btn_sw_debounce #(.NBTN(NBTN), .NSW(NSW), .DEB_CYCLES(DEB_B)) dut_b (
    .clk(clk), .rst(rst), .btn_in(btn_in), .sw_in(sw_in),
    .btn_out(btn_out_b), .btn_pulse(btn_pulse_b), .sw_out(sw_out_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s cycle=%0d got=%0h want=%0h", name, cycle, got, want);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [NBTN-1:0] b, input logic [NSW-1:0] s);
    @(negedge clk);
    rst    = r;
    btn_in = b;
    sw_in  = s;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Model: an input is accepted once its last DEB delayed samples all differ
  // from the accepted level; a reset clears everything.
  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      m_deb = (m == 0) ? DEB_A : DEB_B;
      m_e   = '0;
      for (int ch = 0; ch < NCH; ch++) begin
        if (ch < NBTN) m_raw = btn_in[ch];
        else           m_raw = sw_in[ch - NBTN];
        m_pul = 1'b0;
        if (rst) begin
          m_d1[m][ch]  = 1'b0;
          m_d2[m][ch]  = 1'b0;
          m_st[m][ch]  = 1'b0;
          m_len[m][ch] = 0;
        end else begin
          for (int k = HMAX - 1; k > 0; k--) m_hist[m][ch][k] = m_hist[m][ch][k-1];
          m_hist[m][ch][0] = m_d2[m][ch];
          if (m_len[m][ch] < HMAX) m_len[m][ch]++;
          m_alldiff = (m_len[m][ch] >= m_deb);
          for (int k = 0; k < m_deb; k++)
            if (m_hist[m][ch][k] == m_st[m][ch]) m_alldiff = 1'b0;
          if (m_alldiff) begin
            m_st[m][ch] = !m_st[m][ch];
            m_pul = m_st[m][ch] && (ch < NBTN);
          end
          m_d2[m][ch] = m_d1[m][ch];
          m_d1[m][ch] = m_raw;
        end
        if (ch < NBTN) begin
          m_e[21 + ch] = m_st[m][ch];
          m_e[16 + ch] = m_pul;
        end else begin
          m_e[ch - NBTN] = m_st[m][ch];
        end
      end
      if (m == 0) q_a.push_back(m_e);
      else        q_b.push_back(m_e);
    end
  end

  // Monitor: one expected word per DUT per clock, compared just after the edge
  always @(posedge clk) begin
    #1;
    cycle++;
    if (q_a.size() == 0) checkOutput("sb_a_empty", 32'd1, 32'd0);
    else checkOutput("sb_deb8", {6'd0, btn_out_a, btn_pulse_a, sw_out_a}, {6'd0, q_a.pop_front()});
    if (q_b.size() == 0) checkOutput("sb_b_empty", 32'd1, 32'd0);
    else checkOutput("sb_deb1", {6'd0, btn_out_b, btn_pulse_b, sw_out_b}, {6'd0, q_b.pop_front()});
  end

  int pcount [NBTN];
  logic seen;

  initial begin
    total = 0; bad = 0; cycle = 0;
    rst = 1'b1; btn_in = '0; sw_in = '0;

    // Reset with every input high, then release and count press pulses
    applyStimulus(1'b1, 5'h1F, 16'hFFFF);
    idle(2);
    applyStimulus(1'b0, 5'h1F, 16'hFFFF);
    for (int b = 0; b < NBTN; b++) pcount[b] = 0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (i == 9)  checkOutput("rst_release_early", {27'd0, btn_out_a}, 32'h0);
      if (i == 10) checkOutput("rst_release_sw", {16'd0, sw_out_a}, 32'hFFFF);
      for (int b = 0; b < NBTN; b++) pcount[b] += int'(btn_pulse_a[b]);
    end
    for (int b = 0; b < NBTN; b++) checkOutput("rst_release_pulses", pcount[b], 1);
    applyStimulus(1'b0, '0, '0);
    idle(12);

    // Clean press and release of button 2
    applyStimulus(1'b0, 5'h04, '0);
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      if (i == 9)  checkOutput("press_early", btn_out_a[2], 1'b0);
      if (i == 10) checkOutput("press_level", {btn_out_a[2], btn_pulse_a[2]}, 2'b11);
      if (i == 11) checkOutput("press_width", btn_pulse_a[2], 1'b0);
    end
    idle(8);
    applyStimulus(1'b0, '0, '0);
    seen = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      seen |= btn_pulse_a[2];
      if (i == 9)  checkOutput("release_early", btn_out_a[2], 1'b1);
      if (i == 10) checkOutput("release_level", btn_out_a[2], 1'b0);
    end
    checkOutput("release_no_pulse", seen, 1'b0);
    idle(4);

    // Bouncing switch 0, then a steady high
    for (int l = 0; l < 5; l++) begin
      applyStimulus(1'b0, '0, {15'd0, ~l[0]});
      idle(2);
    end
    idle(14);
    applyStimulus(1'b0, '0, '0);
    idle(12);

    // Seven-cycle glitch on button 4 must be rejected
    applyStimulus(1'b0, 5'h10, '0);
    idle(6);
    applyStimulus(1'b0, '0, '0);
    seen = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      seen |= btn_out_a[4] | btn_pulse_a[4];
    end
    checkOutput("glitch_rejected", seen, 1'b0);

    // Reset in the middle of a count on button 1
    applyStimulus(1'b0, 5'h02, '0);
    idle(4);
    applyStimulus(1'b1, 5'h02, '0);
    applyStimulus(1'b0, 5'h02, '0);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 9)  checkOutput("midreset_early", btn_out_a[1], 1'b0);
      if (i == 10) checkOutput("midreset_level", btn_out_a[1], 1'b1);
    end
    applyStimulus(1'b0, '0, '0);
    idle(12);

    // All inputs rise together
    applyStimulus(1'b0, 5'h1F, 16'hFFFF);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 3) checkOutput("parallel_deb1", {btn_out_b, btn_pulse_b, sw_out_b}, 26'h3FF_FFFF);
      if (i == 10) checkOutput("parallel_deb8", {btn_out_a, btn_pulse_a, sw_out_a}, 26'h3FF_FFFF);
    end
    applyStimulus(1'b0, '0, '0);
    idle(12);

    // Randomised toggling with occasional resets
    for (int i = 0; i < 3000; i++) begin
      logic [NBTN-1:0] b;
      logic [NSW-1:0]  s;
      logic            r;
      int              ch;
      b = btn_in; s = sw_in; r = 1'b0;
      if ($urandom_range(0, 5) == 0) begin
        ch = $urandom_range(0, NCH - 1);
        if (ch < NBTN) b[ch] = ~b[ch];
        else           s[ch - NBTN] = ~s[ch - NBTN];
      end
      if ($urandom_range(0, 199) == 0) r = 1'b1;
      if ($urandom_range(0, 299) == 0) begin
        b = ~b; s = ~s;
      end
      applyStimulus(r, b, s);
    end
    applyStimulus(1'b0, '0, '0);
    idle(14);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
